// File: rtl/ahb_arb_pkg.sv
// Shared types for the AHB master request arbiter.
// Holds the FSM state encoding and a reference round-robin pick.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  localparam int MAX_REQ = 8;

  // Next set bit after 'last', wrapping modulo n; returns 'last' if none
  function automatic logic [2:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         last,
    input int                 n
  );
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= n && !found) begin
        idx = 3'((int'(last) + i) % n);
        if (req[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin picker: rotate so the slot after 'last'
// sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_arbiter_core #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [ID_W-1:0]    pick_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W:0]      start;
  logic [ID_W:0]      off;
  logic [ID_W:0]      sum;

  always_comb begin
    start = (ID_W+1)'(last_i) + (ID_W+1)'(1);
    if (start >= (ID_W+1)'(NUM_REQ)) begin
      start = '0;
    end
    rot = NUM_REQ'({req_i, req_i} >> start);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = (ID_W+1)'(i);
      end
    end
    sum = start + off;
    if (sum >= (ID_W+1)'(NUM_REQ)) begin
      sum = sum - (ID_W+1)'(NUM_REQ);
    end
    pick_o = sum[ID_W-1:0];
    any_o  = |req_i;
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin share of the single ahb_master command port; the grant
// is held through accept (writes) or read-data return (reads).
module ahb_master_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = 2
) (
  input  logic                          i_clk_ahb,
  input  logic                          i_rst_ahb,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_req_rd_valid,
  output logic [DATA_WIDTH-1:0]         o_req_rd_data,
  output logic                          o_valid,
  output logic                          o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  input  logic                          i_ready,
  input  logic                          i_rd_valid,
  input  logic [DATA_WIDTH-1:0]         i_rd_data,
  input  logic                          i_sleep_req,
  output logic                          o_sleep_ack,
  output logic [ID_W-1:0]               o_grant_id,
  output logic                          o_busy
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] last_q, last_d;
  logic            ack_q, ack_d;
  logic [ID_W-1:0] pick;
  logic            pick_any;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_core (
    .req_i  (i_req_valid),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
    end
  end

  // Ack rises only from a quiet IDLE and drops as soon as the request goes
  assign ack_d = i_sleep_req & (ack_q | (state_q == IDLE));

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    o_valid        = 1'b0;
    o_rd0_wr1      = 1'b0;
    o_addr         = '0;
    o_wr_data      = '0;
    o_req_ready    = '0;
    o_req_rd_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (!i_sleep_req && !ack_q && pick_any) begin
          gnt_d   = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        o_valid   = i_req_valid[gnt_q] & ~ack_q;
        o_rd0_wr1 = i_req_rd0_wr1[gnt_q];
        o_addr    = i_req_addr[gnt_q*ADDR_WIDTH +: ADDR_WIDTH];
        o_wr_data = i_req_wr_data[gnt_q*DATA_WIDTH +: DATA_WIDTH];
        o_req_ready[gnt_q] = i_ready & ~ack_q;
        if (!i_req_valid[gnt_q]) begin
          state_d = IDLE;
        end else if (i_ready) begin
          if (i_req_rd0_wr1[gnt_q]) begin
            last_d  = gnt_q;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (i_rd_valid) begin
          o_req_rd_valid[gnt_q] = 1'b1;
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_req_rd_data = i_rd_data;
  assign o_sleep_ack   = ack_q;
  assign o_grant_id    = gnt_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: arbitration table plus
// read-hold, stall, sleep and mid-read reset sequences.
module tb_ahb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_rdwr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  req_rd_valid;
  logic [DW-1:0] req_rd_data;
  logic          m_valid;
  logic          m_rdwr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic          m_rd_valid;
  logic [DW-1:0] m_rd_data;
  logic          sleep_req;
  logic          sleep_ack;
  logic [IW-1:0] grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] addr_tab [N];
  logic [DW-1:0] data_tab [N];

  typedef struct {
    logic [N-1:0]  valid;
    logic [IW-1:0] exp;
  } vec_t;
  vec_t tbl [12];

  always #5 clk = ~clk;

  ahb_master_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_W       (IW)
  ) dut (
    .i_clk_ahb      (clk),
    .i_rst_ahb      (rst),
    .i_req_valid    (req_valid),
    .i_req_rd0_wr1  (req_rdwr),
    .i_req_addr     (req_addr),
    .i_req_wr_data  (req_wdata),
    .o_req_ready    (req_ready),
    .o_req_rd_valid (req_rd_valid),
    .o_req_rd_data  (req_rd_data),
    .o_valid        (m_valid),
    .o_rd0_wr1      (m_rdwr),
    .o_addr         (m_addr),
    .o_wr_data      (m_wdata),
    .i_ready        (m_ready),
    .i_rd_valid     (m_rd_valid),
    .i_rd_data      (m_rd_data),
    .i_sleep_req    (sleep_req),
    .o_sleep_ack    (sleep_ack),
    .o_grant_id     (grant_id),
    .o_busy         (busy)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_issue(input string nm, input int id);
    chk({nm, "_valid"}, 32'(m_valid), 32'd1);
    chk({nm, "_gnt"}, 32'(grant_id), 32'(id));
    chk({nm, "_addr"}, m_addr, addr_tab[id]);
  endtask

  initial begin
    addr_tab = '{32'h0000_1000, 32'h0000_1100,
                 32'h0000_0020, 32'h0000_3300};
    data_tab = '{32'hDEAD_BEEF, 32'h1111_1111,
                 32'h2222_2222, 32'h3333_3333};
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW]  = addr_tab[k];
      req_wdata[k*DW +: DW] = data_tab[k];
    end
    tbl[0]  = '{4'b0001, 2'd0};
    tbl[1]  = '{4'b1111, 2'd1};
    tbl[2]  = '{4'b1111, 2'd2};
    tbl[3]  = '{4'b1111, 2'd3};
    tbl[4]  = '{4'b1111, 2'd0};
    tbl[5]  = '{4'b1000, 2'd3};
    tbl[6]  = '{4'b1001, 2'd0};
    tbl[7]  = '{4'b0110, 2'd1};
    tbl[8]  = '{4'b0101, 2'd2};
    tbl[9]  = '{4'b0011, 2'd0};
    tbl[10] = '{4'b0100, 2'd2};
    tbl[11] = '{4'b0010, 2'd1};

    rst = 1'b1;
    req_valid = '0;
    req_rdwr = '1;
    m_ready = 1'b1;
    m_rd_valid = 1'b0;
    m_rd_data = '0;
    sleep_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(grant_id), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ack", 32'(sleep_ack), 32'd0);
    chk("rst_addr", m_addr, 32'd0);

    // Write arbitration table; one idle cycle after every accept
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid;
      tick();
      #1;
      chk_issue("tbl", int'(tbl[i].exp));
      chk("tbl_wdata", m_wdata, data_tab[tbl[i].exp]);
      chk("tbl_ready", 32'(req_ready), 32'(4'b0001 << tbl[i].exp));
      tick();
      #1;
      chk("tbl_idle", 32'(busy), 32'd0);
      chk("tbl_idle_rdy", 32'(req_ready), 32'd0);
    end

    // Read by 2 holds grant while 1 waits
    req_valid = 4'b0110;
    req_rdwr  = 4'b1011;
    tick();
    #1;
    chk_issue("rd", 2);
    chk("rd_dir", 32'(m_rdwr), 32'd0);
    tick();
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rd_wait_busy", 32'(busy), 32'd1);
      chk("rd_wait_valid", 32'(m_valid), 32'd0);
      chk("rd_wait_rdy", 32'(req_ready), 32'd0);
      chk("rd_wait_strb", 32'(req_rd_valid), 32'd0);
      tick();
    end
    m_rd_valid = 1'b1;
    m_rd_data  = 32'h1234_5678;
    #1;
    chk("rd_strb", 32'(req_rd_valid), 32'b0100);
    chk("rd_data", req_rd_data, 32'h1234_5678);
    tick();
    m_rd_valid = 1'b0;
    #1;
    chk("rd_after_idle", 32'(busy), 32'd0);
    tick();
    #1;
    chk_issue("rd_next", 1);
    tick();
    req_valid = '0;
    req_rdwr  = '1;

    // Command stall: payload held, nobody else ready
    req_valid = 4'b1001;
    m_ready   = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_issue("stall", 3);
      chk("stall_rdy", 32'(req_ready), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    #1;
    chk("stall_acc", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001;
    tick();
    #1;
    chk_issue("stall_next", 0);
    tick();
    req_valid = '0;

    // Sleep requested mid-read
    req_valid = 4'b0010;
    req_rdwr  = 4'b1101;
    tick();
    #1;
    chk_issue("slp_rd", 1);
    tick();
    req_valid = '0;
    req_rdwr  = '1;
    sleep_req = 1'b1;
    tick();
    #1;
    chk("slp_wait_ack", 32'(sleep_ack), 32'd0);
    chk("slp_wait_busy", 32'(busy), 32'd1);
    m_rd_valid = 1'b1;
    m_rd_data  = 32'hCAFE_0001;
    #1;
    chk("slp_strb", 32'(req_rd_valid), 32'b0010);
    tick();
    m_rd_valid = 1'b0;
    req_valid  = 4'b0010;
    #1;
    chk("slp_ack_lag", 32'(sleep_ack), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("slp_ack", 32'(sleep_ack), 32'd1);
      chk("slp_nogrant", 32'(busy), 32'd0);
      chk("slp_novalid", 32'(m_valid), 32'd0);
      tick();
    end
    sleep_req = 1'b0;
    tick();
    #1;
    chk("slp_ack_clr", 32'(sleep_ack), 32'd0);
    chk("slp_still_idle", 32'(busy), 32'd0);
    tick();
    #1;
    chk_issue("slp_grant", 1);
    tick();
    req_valid = '0;

    // Reset abandons an in-flight read
    req_valid = 4'b1000;
    req_rdwr  = 4'b0111;
    tick();
    #1;
    chk_issue("rr_rd", 3);
    tick();
    req_valid = '0;
    req_rdwr  = '1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_rd_valid = 1'b1;
    #1;
    chk("rr_nostrb", 32'(req_rd_valid), 32'd0);
    chk("rr_idle", 32'(busy), 32'd0);
    chk("rr_gnt", 32'(grant_id), 32'd0);
    tick();
    m_rd_valid = 1'b0;
    req_valid  = 4'b1001;
    tick();
    #1;
    chk_issue("rr_first", 0);
    tick();
    req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares the single sink-side ahb_master valid/ready command port among NUM_REQ independent requesters, for example several sink controllers or bridge channels.
- Uses round-robin arbitration.
- Holds the grant for the full transaction: until accept for writes, until read data returns for reads.
- Provides a sleep-drain handshake so the power sequencing can quiesce the AHB master cleanly.
- Sits between the requesters and ahb_master, in the sink clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- ID_W, 2, grant index width; must equal clog2(NUM_REQ).

Ports:
- i_clk_ahb  in  1  sink/AHB clock.
- i_rst_ahb  in  1  reset; synchronous, active-high.
- i_req_valid  in  NUM_REQ  per-requester command valid.
- i_req_rd0_wr1  in  NUM_REQ  per-requester direction (0 = read, 1 = write).
- i_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k occupies slice k.
- i_req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- o_req_ready  out  NUM_REQ  per-requester command accept.
- o_req_rd_valid  out  NUM_REQ  per-requester read-data strobe.
- o_req_rd_data  out  DATA_WIDTH  read data, broadcast to all requesters.
- o_valid  out  1  command valid to ahb_master.
- o_rd0_wr1  out  1  direction to ahb_master.
- o_addr  out  ADDR_WIDTH  address to ahb_master.
- o_wr_data  out  DATA_WIDTH  write data to ahb_master.
- i_ready  in  1  ahb_master command accept.
- i_rd_valid  in  1  ahb_master read data valid.
- i_rd_data  in  DATA_WIDTH  ahb_master read data.
- i_sleep_req  in  1  request to quiesce.
- o_sleep_ack  out  1  quiesced; no transaction outstanding.
- o_grant_id  out  ID_W  registered current or last grant index.
- o_busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (synchronous, i_rst_ahb=1):
  - state=IDLE, last_gnt=NUM_REQ-1, so requester 0 wins first.
  - gnt=0, o_grant_id=0, o_sleep_ack=0.
  - All outputs are 0.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If i_sleep_req=0 and any i_req_valid is set, pick the first set bit scanning last_gnt+1, last_gnt+2, … modulo NUM_REQ.
  - Register that index into gnt, then go to ISSUE.
  - Arbitration latency: 1 cycle from valid to ISSUE.
  - No o_valid is driven in IDLE.
- ISSUE:
  - o_valid = i_req_valid[gnt].
  - o_rd0_wr1, o_addr and o_wr_data are muxed from slice gnt (combinational).
  - o_req_ready[gnt] = i_ready; all other ready bits are 0.
  - Handshake occurs when o_valid & i_ready. Then:
    - write: last_gnt<=gnt, go to IDLE;
    - read: go to WAIT_RD.
  - Requesters must hold valid and payload stable until ready.
  - If i_req_valid[gnt] drops before the handshake (protocol violation), return to IDLE with last_gnt unchanged.
- WAIT_RD:
  - o_valid=0.
  - When i_rd_valid=1: o_req_rd_valid[gnt]=1 for that cycle, o_req_rd_data=i_rd_data, last_gnt<=gnt, go to IDLE.
  - o_req_rd_data always passes i_rd_data through; it is meaningful only with the strobe.
  - i_rd_valid received in IDLE or ISSUE is ignored, with no strobe to any requester.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,2,3,0,…
  - Maximum wait for any requester is NUM_REQ-1 transactions.
- Back-to-back: each transaction returns through IDLE, so there is at least 1 idle cycle between commands. This is the accepted throughput cost.
- Sleep:
  - i_sleep_req blocks new grants in IDLE only.
  - A transaction already in ISSUE or WAIT_RD completes normally.
  - o_sleep_ack is registered: set the cycle after state==IDLE && i_sleep_req; cleared the cycle after i_sleep_req falls.
  - While o_sleep_ack=1, all o_req_ready=0 and o_valid=0.
- Reset mid-transaction forces IDLE immediately. An in-flight read is abandoned and its strobe is never issued.
- o_grant_id is updated when gnt is registered.

Decomposition:
- Package ahb_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_RD);
  - a function rr_pick(req vector, last index) that returns the next index.
- One sub-module: rr_arbiter_core.
  - Combinational rotate / priority-encode / rotate-back.
  - Parameterised by NUM_REQ.
  - Unit-testable on its own.

Test Plan:
- Reset, then req_valid=4'b0001 write addr 0x1000 data 0xDEAD_BEEF, i_ready=1 → o_valid high 1 cycle after valid; o_addr=0x1000; o_req_ready[0] pulses; o_grant_id=0; back to IDLE.
- req_valid=4'b1111 held, all writes, i_ready=1 → grant order 0,1,2,3,0; each o_req_ready pulse is separated by 1 IDLE cycle.
- Requester 2 read addr 0x20, i_rd_valid returned 5 cycles after accept with 0x1234_5678; requester 1 valid meanwhile → o_req_rd_valid[2] pulses with data 0x1234_5678; requester 1 is not granted until after the strobe.
- i_ready held 0 for 4 cycles during ISSUE → o_valid and payload stable for 4 cycles; other requesters get no ready.
- i_sleep_req asserted during WAIT_RD → read completes, then o_sleep_ack=1 the cycle after IDLE; pending req_valid=4'b0010 is not granted until sleep_req drops and ack clears.
- Reset asserted in WAIT_RD, then i_rd_valid=1 → no o_req_rd_valid; state IDLE; next grant goes to requester 0.
